// File: rtl/loteria_pkg.sv
// Shared definitions for the lottery bet sequencer and the lottery checker:
// FSM state encoding, digit limits and prize codes.
package loteria_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_SEND  = 3'd2,
        ST_GAP   = 3'd3,
        ST_FIN   = 3'd4,
        ST_WAIT  = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    localparam int BCD_MAX    = 9;
    localparam int NUM_DIGITS = 5;

    // Index of the last digit; the digit counter stops here and never wraps
    localparam logic [2:0] LAST_DIGIT = 3'(NUM_DIGITS - 1);

    localparam logic [1:0] PRIZE_NONE   = 2'd0;
    localparam logic [1:0] PRIZE_FIRST  = 2'd1;
    localparam logic [1:0] PRIZE_SECOND = 2'd2;

    // True when every nibble of a 5-digit ticket is a legal BCD digit
    function automatic logic ticket_is_bcd(input logic [19:0] t);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (t[i*4 +: 4] > 4'(BCD_MAX)) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/loteria_timer.sv
// 4-bit loadable down-counter with a zero flag. Shared by the inter-digit
// gap and the response wait; a load always wins over a decrement and the
// count parks at zero.
module loteria_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] count;

    // Reload on request, otherwise count down until zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 4'd0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != 4'd0)) begin
            count <= count - 4'd1;
        end
    end

    assign zero = (count == 4'd0);

endmodule

// File: rtl/loteria_apostador.sv
// Bet sequencer: latches a 5-digit BCD ticket, validates it, sends one
// insert strobe per digit (most significant first), then a finish strobe,
// waits RESP_DLY cycles and captures the checker's win/prize result.
//
// Handshake: start is a level request sampled only while busy is low; the
// ticket is taken on the same edge. A request seen while busy is dropped,
// so holding start high produces back-to-back transactions.
module loteria_apostador
    import loteria_pkg::*;
#(
    parameter int GAP      = 2,
    parameter int RESP_DLY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [19:0] ticket,
    input  logic        win_in,
    input  logic [1:0]  prize_in,
    output logic [3:0]  num,
    output logic        insert,
    output logic        finish,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        win,
    output logic [1:0]  prize,
    output logic [2:0]  dbg_state
);

    // Timer reloads: it is checked for zero in GAP/WAIT, so loading N-1
    // makes the state last exactly N cycles.
    localparam logic [3:0] GAP_LOAD  = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
    localparam logic [3:0] RESP_LOAD = 4'(RESP_DLY - 1);

    state_t      state;
    logic [19:0] shreg;
    logic [2:0]  digit_cnt;
    logic        timer_load;
    logic [3:0]  timer_val;
    logic        timer_dec;
    logic        timer_zero;

    // Timer control: arm on leaving SEND (gap) or in FIN (response wait)
    always_comb begin
        timer_load = ((state == ST_SEND) && (GAP != 0)) || (state == ST_FIN);
        timer_val  = (state == ST_FIN) ? RESP_LOAD : GAP_LOAD;
        timer_dec  = (state == ST_GAP) || (state == ST_WAIT);
    end

    loteria_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .dec      (timer_dec),
        .zero     (timer_zero)
    );

    // Main sequencer; num is loaded on every transition into SEND so it is
    // valid in the same cycle as the insert strobe and holds afterwards
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            shreg     <= 20'd0;
            digit_cnt <= 3'd0;
            num       <= 4'd0;
            err       <= 1'b0;
            win       <= 1'b0;
            prize     <= PRIZE_NONE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        shreg     <= ticket;
                        digit_cnt <= 3'd0;
                        err       <= 1'b0;
                        state     <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (!ticket_is_bcd(shreg)) begin
                        err   <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        num   <= shreg[19:16];
                        shreg <= {shreg[15:0], 4'h0};
                        state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (GAP != 0) begin
                        state <= ST_GAP;
                    end else if (digit_cnt == LAST_DIGIT) begin
                        state <= ST_FIN;
                    end else begin
                        num       <= shreg[19:16];
                        shreg     <= {shreg[15:0], 4'h0};
                        digit_cnt <= digit_cnt + 3'd1;
                        state     <= ST_SEND;
                    end
                end
                ST_GAP: begin
                    if (timer_zero) begin
                        if (digit_cnt == LAST_DIGIT) begin
                            state <= ST_FIN;
                        end else begin
                            num       <= shreg[19:16];
                            shreg     <= {shreg[15:0], 4'h0};
                            digit_cnt <= digit_cnt + 3'd1;
                            state     <= ST_SEND;
                        end
                    end
                end
                ST_FIN: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (timer_zero) begin
                        win   <= win_in;
                        prize <= prize_in;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Moore strobes decoded straight from the state register
    always_comb begin
        insert    = (state == ST_SEND);
        finish    = (state == ST_FIN);
        busy      = (state != ST_IDLE);
        done      = (state == ST_DONE);
        dbg_state = state;
    end

endmodule

// File: tb/tb_loteria_apostador.sv
// Bench for loteria_apostador. Three instances with different GAP/RESP_DLY
// share one stimulus stream. A transaction-level model turns each accepted
// start into a per-cycle schedule of expected strobes, busy/err levels and
// digits; a negedge monitor compares every instance against it each cycle.
module tb_loteria_apostador;
    import loteria_pkg::*;

    localparam int N  = 4096;
    localparam int NI = 3;
    localparam int GAP_P [NI] = '{2, 0, 15};
    localparam int RD_P  [NI] = '{2, 2, 15};

    logic        clk;
    logic        reset;
    logic        start;
    logic [19:0] ticket;
    logic        win_in;
    logic [1:0]  prize_in;

    logic [3:0]  num_o    [NI];
    logic        insert_o [NI];
    logic        finish_o [NI];
    logic        busy_o   [NI];
    logic        done_o   [NI];
    logic        err_o    [NI];
    logic        win_o    [NI];
    logic [1:0]  prize_o  [NI];
    logic [2:0]  dbg_o    [NI];

    loteria_apostador #(.GAP(GAP_P[0]), .RESP_DLY(RD_P[0])) u_dut0 (
        .clk(clk), .reset(reset), .start(start), .ticket(ticket),
        .win_in(win_in), .prize_in(prize_in), .num(num_o[0]),
        .insert(insert_o[0]), .finish(finish_o[0]), .busy(busy_o[0]),
        .done(done_o[0]), .err(err_o[0]), .win(win_o[0]),
        .prize(prize_o[0]), .dbg_state(dbg_o[0])
    );

    loteria_apostador #(.GAP(GAP_P[1]), .RESP_DLY(RD_P[1])) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .ticket(ticket),
        .win_in(win_in), .prize_in(prize_in), .num(num_o[1]),
        .insert(insert_o[1]), .finish(finish_o[1]), .busy(busy_o[1]),
        .done(done_o[1]), .err(err_o[1]), .win(win_o[1]),
        .prize(prize_o[1]), .dbg_state(dbg_o[1])
    );

    loteria_apostador #(.GAP(GAP_P[2]), .RESP_DLY(RD_P[2])) u_dut2 (
        .clk(clk), .reset(reset), .start(start), .ticket(ticket),
        .win_in(win_in), .prize_in(prize_in), .num(num_o[2]),
        .insert(insert_o[2]), .finish(finish_o[2]), .busy(busy_o[2]),
        .done(done_o[2]), .err(err_o[2]), .win(win_o[2]),
        .prize(prize_o[2]), .dbg_state(dbg_o[2])
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard state ----------------
    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int mode = 0;  // 0 random checker answer, 1 win/prize 01, 2 lose/prize 00

    int free_at  [NI];
    int exp_ins  [NI][N];
    int exp_fin  [NI][N];
    int exp_done [NI][N];
    int exp_busy [NI][N];
    int exp_err  [NI][N];
    int cap_at   [NI][N];
    int win_log   [N];
    int prize_log [N];
    int hold_num   [NI];
    int hold_win   [NI];
    int hold_prize [NI];

    // Expected digit stream per instance, in send order
    logic [3:0] exp_q0[$];
    logic [3:0] exp_q1[$];
    logic [3:0] exp_q2[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void push_dig(input int i, input logic [3:0] d);
        case (i)
            0: exp_q0.push_back(d);
            1: exp_q1.push_back(d);
            default: exp_q2.push_back(d);
        endcase
    endfunction

    function automatic int pop_dig(input int i, input int dflt);
        int r;
        r = dflt;
        case (i)
            0: if (exp_q0.size() > 0) r = int'(exp_q0.pop_front());
            1: if (exp_q1.size() > 0) r = int'(exp_q1.pop_front());
            default: if (exp_q2.size() > 0) r = int'(exp_q2.pop_front());
        endcase
        return r;
    endfunction

    // Schedule everything an accepted start at cycle k implies
    function automatic void accept(input int i, input int k, input logic [19:0] t);
        int g;
        int rd;
        int f;
        int c;
        bit bad;
        logic [3:0] d;
        g = GAP_P[i];
        rd = RD_P[i];
        bad = 1'b0;
        for (int j = 0; j < 5; j++) begin
            d = t[19 - 4*j -: 4];
            if (d > 4'd9) bad = 1'b1;
        end
        for (int x = k + 1; x < N; x++) exp_err[i][x] = 0;
        exp_busy[i][k+1] = 1;
        if (bad) begin
            for (int x = k + 2; x < N; x++) exp_err[i][x] = 1;
            free_at[i] = k + 2;
        end else begin
            for (int j = 0; j < 5; j++) begin
                c = k + 2 + j * (g + 1);
                exp_ins[i][c] = 1;
                push_dig(i, t[19 - 4*j -: 4]);
            end
            f = k + 2 + 5 * (g + 1);
            exp_fin[i][f] = 1;
            for (int x = k + 2; x <= f + rd + 1; x++) exp_busy[i][x] = 1;
            exp_done[i][f+rd+1] = 1;
            cap_at[i][f+rd+1] = f + rd;
            free_at[i] = f + rd + 2;
        end
    endfunction

    // Forget every expectation from cycle 'from' onwards (reset)
    function automatic void clear_model(input int i, input int from);
        for (int x = from; x < N; x++) begin
            exp_ins[i][x] = 0;
            exp_fin[i][x] = 0;
            exp_done[i][x] = 0;
            exp_busy[i][x] = 0;
            exp_err[i][x] = 0;
            cap_at[i][x] = 0;
        end
        hold_num[i] = 0;
        hold_win[i] = 0;
        hold_prize[i] = 0;
        free_at[i] = from;
    endfunction

    // Model: sample inputs at every rising edge, then advance the cycle index
    initial begin
        forever begin
            @(posedge clk);
            if (cyc < N) begin
                win_log[cyc] = int'(win_in);
                prize_log[cyc] = int'(prize_in);
            end
            if (!reset && start && cyc < N - 200) begin
                for (int i = 0; i < NI; i++) begin
                    if (cyc >= free_at[i]) accept(i, cyc, ticket);
                end
            end
            cyc = cyc + 1;
        end
    end

    // Monitor: compare every instance against the schedule mid-cycle
    initial begin
        forever begin
            @(negedge clk);
            if (cyc < N) begin
                for (int i = 0; i < NI; i++) begin
                    if (exp_ins[i][cyc] != 0) hold_num[i] = pop_dig(i, hold_num[i]);
                    if (exp_done[i][cyc] != 0) begin
                        hold_win[i] = win_log[cap_at[i][cyc]];
                        hold_prize[i] = prize_log[cap_at[i][cyc]];
                    end
                    check($sformatf("u%0d@%0d insert", i, cyc), 32'(insert_o[i]), 32'(exp_ins[i][cyc]));
                    check($sformatf("u%0d@%0d finish", i, cyc), 32'(finish_o[i]), 32'(exp_fin[i][cyc]));
                    check($sformatf("u%0d@%0d done", i, cyc), 32'(done_o[i]), 32'(exp_done[i][cyc]));
                    check($sformatf("u%0d@%0d busy", i, cyc), 32'(busy_o[i]), 32'(exp_busy[i][cyc]));
                    check($sformatf("u%0d@%0d err", i, cyc), 32'(err_o[i]), 32'(exp_err[i][cyc]));
                    check($sformatf("u%0d@%0d num", i, cyc), 32'(num_o[i]), 32'(hold_num[i]));
                    check($sformatf("u%0d@%0d win", i, cyc), 32'(win_o[i]), 32'(hold_win[i]));
                    check($sformatf("u%0d@%0d prize", i, cyc), 32'(prize_o[i]), 32'(hold_prize[i]));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [19:0] gen_ticket(input bit allow_bad);
        logic [19:0] t;
        int p;
        for (int j = 0; j < 5; j++) t[4*j +: 4] = 4'($urandom_range(0, 9));
        if (allow_bad && $urandom_range(0, 5) == 0) begin
            p = $urandom_range(0, 4);
            t[4*p +: 4] = 4'($urandom_range(10, 15));
        end
        return t;
    endfunction

    task automatic drive_cycle(input logic s, input logic [19:0] t);
        start = s;
        ticket = t;
        case (mode)
            1: begin win_in = 1'b1; prize_in = PRIZE_FIRST; end
            2: begin win_in = 1'b0; prize_in = PRIZE_NONE; end
            default: begin
                win_in = 1'($urandom_range(0, 1));
                prize_in = 2'($urandom_range(0, 2));
            end
        endcase
        @(posedge clk);
        #1;
    endtask

    function automatic bit any_busy();
        bit b;
        b = 1'b0;
        for (int i = 0; i < NI; i++) if (free_at[i] > cyc) b = 1'b1;
        return b;
    endfunction

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (any_busy() && guard < 400) begin
            drive_cycle(1'b0, gen_ticket(1'b0));
            guard++;
        end
        if (any_busy()) check("idle_timeout", 32'd1, 32'd0);
        drive_cycle(1'b0, 20'd0);
    endtask

    task automatic reset_mid();
        reset = 1'b1;
        for (int i = 0; i < NI; i++) clear_model(i, cyc);
        exp_q0.delete();
        exp_q1.delete();
        exp_q2.delete();
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("u%0d rst insert", i), 32'(insert_o[i]), 32'd0);
            check($sformatf("u%0d rst finish", i), 32'(finish_o[i]), 32'd0);
            check($sformatf("u%0d rst busy", i), 32'(busy_o[i]), 32'd0);
            check($sformatf("u%0d rst done", i), 32'(done_o[i]), 32'd0);
            check($sformatf("u%0d rst err", i), 32'(err_o[i]), 32'd0);
            check($sformatf("u%0d rst num", i), 32'(num_o[i]), 32'd0);
            check($sformatf("u%0d rst win", i), 32'(win_o[i]), 32'd0);
            check($sformatf("u%0d rst prize", i), 32'(prize_o[i]), 32'd0);
            check($sformatf("u%0d rst state", i), 32'(dbg_o[i]), 32'(ST_IDLE));
        end
        drive_cycle(1'b0, 20'd0);
        drive_cycle(1'b0, 20'd0);
        reset = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        reset = 1'b1;
        start = 1'b0;
        ticket = 20'd0;
        win_in = 1'b0;
        prize_in = 2'd0;
        for (int i = 0; i < NI; i++) free_at[i] = 0;
        repeat (3) drive_cycle(1'b0, 20'd0);
        reset = 1'b0;
        repeat (2) drive_cycle(1'b0, 20'd0);

        // Nominal win
        mode = 1;
        drive_cycle(1'b1, 20'h50967);
        wait_idle();

        // Bad digit: no strobes, err sticky
        mode = 0;
        drive_cycle(1'b1, 20'h5A967);
        wait_idle();

        // Back-to-back digit pattern
        mode = 1;
        drive_cycle(1'b1, 20'h12345);
        wait_idle();

        // Start while busy is ignored
        drive_cycle(1'b1, 20'h50967);
        repeat (3) drive_cycle(1'b0, 20'd0);
        drive_cycle(1'b1, 20'h99999);
        wait_idle();

        // Reset between the 2nd and 3rd insert of the GAP=2 instance
        drive_cycle(1'b1, 20'h50967);
        repeat (5) drive_cycle(1'b0, 20'd0);
        reset_mid();
        drive_cycle(1'b1, 20'h50967);
        wait_idle();

        // Start held high, checker reports no prize
        mode = 2;
        repeat (150) drive_cycle(1'b1, gen_ticket(1'b0));
        wait_idle();

        // Random tickets, some invalid, random checker answers
        mode = 0;
        repeat (300) drive_cycle(1'($urandom_range(0, 3) == 0), gen_ticket(1'b1));
        wait_idle();

        repeat (5) drive_cycle(1'b0, 20'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
